// File: rtl/modexp_controller.sv
`default_nettype none
// ==========================================================================
// Module   : modexp_controller
// Purpose  : left-to-right square-and-multiply sequencer computing x^e mod n
//            on one shared serial modular multiplier
// Revision : 1.0
// ==========================================================================
module modexp_controller #(
    parameter int MAX_BITS = 256,
    parameter int CNT_W    = 9
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic [MAX_BITS-1:0] i_x,
    input  logic [MAX_BITS-1:0] i_e,
    output logic                o_busy,
    output logic                o_done,
    output logic [MAX_BITS-1:0] o_result,
    output logic                o_mul_start,
    output logic [MAX_BITS-1:0] o_mul_a,
    output logic [MAX_BITS-1:0] o_mul_b,
    input  logic [MAX_BITS-1:0] i_mul_result,
    input  logic                i_mul_finished
);

    localparam int c_idx_w = $clog2(MAX_BITS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SQ_GO   = 3'd1,
        S_SQ_WAIT = 3'd2,
        S_MU_GO   = 3'd3,
        S_MU_WAIT = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [MAX_BITS-1:0] acc_q, acc_d;
    logic [MAX_BITS-1:0] x_q, x_d;
    logic [MAX_BITS-1:0] e_q, e_d;
    logic [MAX_BITS-1:0] result_q, result_d;
    logic [MAX_BITS-1:0] mul_a_q, mul_a_d;
    logic [MAX_BITS-1:0] mul_b_q, mul_b_d;
    logic [CNT_W-1:0]    k_q, k_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mul_start_q, mul_start_d;

    logic [CNT_W-1:0]    w_top_idx;
    logic                w_e_bit;

    always_comb begin
        case (i_mode)
            2'd0:    w_top_idx = CNT_W'(31);
            2'd1:    w_top_idx = CNT_W'(63);
            2'd2:    w_top_idx = CNT_W'(127);
            default: w_top_idx = CNT_W'(255);
        endcase
    end

    assign w_e_bit = e_q[k_q[c_idx_w-1:0]];

    // Operands and the start pulse are loaded on the transition into a GO
    // state, so they are already stable in the cycle the pulse is visible.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        x_d         = x_q;
        e_d         = e_q;
        result_d    = result_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        k_d         = k_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mul_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    x_d         = i_x;
                    e_d         = i_e;
                    k_d         = w_top_idx;
                    acc_d       = MAX_BITS'(1);
                    busy_d      = 1'b1;
                    mul_start_d = 1'b1;
                    mul_a_d     = MAX_BITS'(1);
                    mul_b_d     = MAX_BITS'(1);
                    state_d     = S_SQ_GO;
                end
            end
            S_SQ_GO: state_d = S_SQ_WAIT;
            S_SQ_WAIT: begin
                if (i_mul_finished) begin
                    acc_d = i_mul_result;
                    if (w_e_bit) begin
                        mul_start_d = 1'b1;
                        mul_a_d     = i_mul_result;
                        mul_b_d     = x_q;
                        state_d     = S_MU_GO;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_MU_GO: state_d = S_MU_WAIT;
            S_MU_WAIT: begin
                if (i_mul_finished) begin
                    acc_d   = i_mul_result;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (k_q == '0) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    k_d         = k_q - CNT_W'(1);
                    mul_start_d = 1'b1;
                    mul_a_d     = acc_q;
                    mul_b_d     = acc_q;
                    state_d     = S_SQ_GO;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            x_q         <= '0;
            e_q         <= '0;
            result_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            e_q         <= e_d;
            result_q    <= result_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mul_start_q <= mul_start_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_result    = result_q;
    assign o_mul_start = mul_start_q;
    assign o_mul_a     = mul_a_q;
    assign o_mul_b     = mul_b_q;

endmodule
`default_nettype wire

// File: tb/tb_modexp_controller.sv
`default_nettype none
// ==========================================================================
// Module   : tb_modexp_controller
// Purpose  : self-checking bench with a behavioural modular multiplier and
//            a right-to-left exponentiation reference
// Revision : 1.0
// ==========================================================================
module tb_modexp_controller;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic [1:0]   mode;
    logic [255:0] x_in, e_in;
    logic         busy, done, mul_start;
    logic [255:0] result, mul_a, mul_b;
    logic [255:0] mul_res;
    logic         mul_fin;

    int n_checks, n_fail;
    int n_starts, stab_err, overlap_err;
    int fixed_lat;
    logic [255:0] mod_n;

    logic         pend;
    int           cnt;
    logic [255:0] cap_a, cap_b, prod;

    always #5 clk = ~clk;

    modexp_controller dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_start        (i_start),
        .i_mode         (mode),
        .i_x            (x_in),
        .i_e            (e_in),
        .o_busy         (busy),
        .o_done         (done),
        .o_result       (result),
        .o_mul_start    (mul_start),
        .o_mul_a        (mul_a),
        .o_mul_b        (mul_b),
        .i_mul_result   (mul_res),
        .i_mul_finished (mul_fin)
    );

    function automatic logic [255:0] mulmod(input logic [255:0] a, b, n);
        logic [511:0] p;
        p = {256'b0, a} * {256'b0, b};
        p = p % {256'b0, n};
        return p[255:0];
    endfunction

    // Right-to-left binary exponentiation over the active exponent bits.
    function automatic logic [255:0] ref_modexp(input logic [255:0] x, e, n, input logic [1:0] md);
        int top;
        logic [255:0] r, b;
        top = (32 << md) - 1;
        r = 256'd1;
        b = mulmod(x, 256'd1, n);
        for (int i = 0; i <= top; i++) begin
            if (e[i]) r = mulmod(r, b, n);
            b = mulmod(b, b, n);
        end
        return r;
    endfunction

    function automatic int exp_starts(input logic [255:0] e, input logic [1:0] md);
        int top, c;
        top = (32 << md) - 1;
        c = top + 1;
        for (int i = 0; i <= top; i++) c += int'(e[i]);
        return c;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp_v);
        end
    endtask

    // Behavioural multiplier: samples operands at the start pulse, answers
    // after a random latency, and watches the operands while pending.
    always @(negedge clk) begin
        mul_fin = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (mul_a !== cap_a || mul_b !== cap_b) stab_err++;
                if (cnt == 0) begin
                    mul_fin = 1'b1;
                    mul_res = prod;
                    pend    = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (mul_start) begin
                if (pend) overlap_err++;
                pend  = 1'b1;
                cap_a = mul_a;
                cap_b = mul_b;
                prod  = mulmod(mul_a, mul_b, mod_n);
                cnt   = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
                n_starts++;
            end
        end
    end

    task automatic run_op(input string nm, input logic [1:0] md, input logic [255:0] n, x, e,
                          input logic [255:0] exp_r, input int restart_at);
        int s0, cyc;
        bit seen;
        mod_n = n;
        @(negedge clk);
        mode = md; x_in = x; e_in = e; i_start = 1'b1;
        s0 = n_starts;
        @(negedge clk);
        i_start = 1'b0;
        chk({nm, "_busy_rise"}, 256'(busy), 256'd1);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20000) begin
            if (cyc == restart_at) begin
                x_in = ~x; e_in = ~e; i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
                chk({nm, "_result"}, result, exp_r);
                chk({nm, "_busy_at_done"}, 256'(busy), 256'd0);
                chk({nm, "_mul_starts"}, 256'(n_starts - s0), 256'(exp_starts(e, md)));
            end
        end
        i_start = 1'b0;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no done within %0d cycles", nm, cyc);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
            chk({nm, "_done_width"}, 256'(done), 256'd0);
            chk({nm, "_result_hold"}, result, exp_r);
        end
        chk({nm, "_operand_stable"}, 256'(stab_err), 256'd0);
        chk({nm, "_single_outstanding"}, 256'(overlap_err), 256'd0);
    endtask

    typedef struct {
        logic [1:0]   md;
        logic [255:0] n, x, e, r;
        bit           use_ref;
    } vec_t;

    initial begin
        vec_t vecs[6];
        logic [255:0] n, x, e;
        logic [1:0] md;
        int s0, cyc;

        n_checks = 0; n_fail = 0; n_starts = 0; stab_err = 0; overlap_err = 0;
        fixed_lat = -1; pend = 1'b0; cnt = 0; mod_n = 256'd23;
        rst_n = 1'b0; i_start = 1'b0; mode = 2'd0; x_in = '0; e_in = '0;
        mul_fin = 1'b0; mul_res = '0;

        vecs[0] = '{2'd0, 256'd23, 256'd5, 256'd3, 256'd10, 1'b0};
        vecs[1] = '{2'd0, 256'd23, 256'd2, 256'd22, 256'd1, 1'b0};
        vecs[2] = '{2'd0, 256'd11, 256'd7, 256'd0, 256'd1, 1'b0};
        vecs[3] = '{2'd0, 256'd11, 256'd7, 256'd1, 256'd7, 1'b0};
        vecs[4] = '{2'd0, 256'hFFFFFFFB, 256'd2, 256'hFFFFFFFA, 256'd1, 1'b0};
        vecs[5] = '{2'd0, 256'hFFFFFFFB, 256'd3, {{224{1'b1}}, 32'h80000000}, 256'd0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_result", result, 256'd0);
        chk("rst_mul_start", 256'(mul_start), 256'd0);
        chk("rst_mul_a", mul_a, 256'd0);
        chk("rst_mul_b", mul_b, 256'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].md, vecs[i].n, vecs[i].x, vecs[i].e,
                   vecs[i].use_ref ? ref_modexp(vecs[i].x, vecs[i].e, vecs[i].n, vecs[i].md) : vecs[i].r,
                   -1);
        end

        for (int i = 0; i < 5; i++) begin
            md = (i < 2) ? 2'd3 : 2'($urandom_range(0, 3));
            n = rand256() | 256'd1;
            if (n < 256'd3) n = 256'd3;
            x = rand256() % n;
            e = rand256();
            run_op($sformatf("rand%0d", i), md, n, x, e, ref_modexp(x, e, n, md), -1);
        end

        run_op("restart32", 2'd0, 256'd23, 256'd5, 256'd3, 256'd10, 40);
        n = rand256() | 256'd1;
        x = rand256() % n;
        e = rand256();
        run_op("restart256", 2'd3, n, x, e, ref_modexp(x, e, n, 2'd3), 300);

        // Reset while the first multiply (32nd start) is outstanding.
        mod_n = 256'd23;
        fixed_lat = 4;
        @(negedge clk);
        mode = 2'd0; x_in = 256'd5; e_in = 256'd3; i_start = 1'b1;
        s0 = n_starts;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 0;
        while ((n_starts - s0) < 32 && cyc < 5000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("rst_mid_reach_mu", 256'(n_starts - s0), 256'd32);
        chk("rst_mid_mul_b_is_x", mul_b, 256'd5);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 256'(busy), 256'd0);
        chk("rst_mid_done", 256'(done), 256'd0);
        chk("rst_mid_result", result, 256'd0);
        chk("rst_mid_mul_start", 256'(mul_start), 256'd0);
        chk("rst_mid_mul_a", mul_a, 256'd0);
        chk("rst_mid_mul_b", mul_b, 256'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fixed_lat = -1;
        run_op("post_rst", 2'd0, 256'd23, 256'd5, 256'd3, 256'd10, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
